// File: rtl/sram_nr1w.sv
// sram_nr1w: multi-read-port, single-write-port SRAM with byte-masked writes and a zeroing sweep.
// The sweep runs after reset and on clear_req; reads are registered, with an optional extra output stage.
module sram_nr1w #(
    parameter  int SETS_NUM   = 64,
    parameter  int DATA_WIDTH = 32,
    parameter  int READ_PORTS = 2,
    parameter  int OUTPUT_REG = 0,
    localparam int AW         = $clog2(SETS_NUM),
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_req,
    output logic                             busy,
    input  logic [READ_PORTS-1:0]            read_en,
    input  logic [READ_PORTS*AW-1:0]         read_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [READ_PORTS-1:0]            read_valid,
    input  logic                             write_en,
    input  logic [AW-1:0]                    write_addr,
    input  logic [BW-1:0]                    write_byte_en,
    input  logic [DATA_WIDTH-1:0]            write_data
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                state, state_nxt;
    logic [AW-1:0]         cnt;
    logic                  idle, wr;
    logic [DATA_WIDTH-1:0] mem [SETS_NUM];
    logic [DATA_WIDTH-1:0] wr_word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == CLEAR) ? cnt + AW'(1) : '0;
        end
    end
    always_comb begin
        state_nxt = (state == CLEAR) ? ((cnt == AW'(SETS_NUM - 1)) ? IDLE : CLEAR)
                                     : (clear_req ? CLEAR : IDLE);
    end
    always_comb begin
        busy = (state == CLEAR);
        idle = (state == IDLE);
        wr   = idle & write_en;
    end
    // Merged word is shared by the array write and the read-during-write bypass.
    always_comb begin
        wr_word = mem[write_addr];
        for (int k = 0; k < BW; k++)
            wr_word[8*k +: 8] = write_byte_en[k] ? write_data[8*k +: 8] : mem[write_addr][8*k +: 8];
    end
    always_ff @(posedge clk) begin
        if (busy)
            mem[cnt] <= '0;
        else if (wr)
            mem[write_addr] <= wr_word;
    end
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
        logic [AW-1:0]         ra;
        logic                  acc, v1;
        logic [DATA_WIDTH-1:0] word, d1;
        assign ra   = read_addr[i*AW +: AW];
        assign acc  = idle & read_en[i];
        assign word = (wr && write_addr == ra) ? wr_word : mem[ra];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1 <= '0;
                v1 <= 1'b0;
            end else begin
                v1 <= acc;
                if (acc)
                    d1 <= word;
            end
        end
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] d2;
            logic                  v2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1)
                        d2 <= d1;
                end
            end
            assign read_data[i*DATA_WIDTH +: DATA_WIDTH] = d2;
            assign read_valid[i]                         = v2;
        end else begin : g_direct
            assign read_data[i*DATA_WIDTH +: DATA_WIDTH] = d1;
            assign read_valid[i]                         = v1;
        end
    end
endmodule

// File: tb/tb_sram_nr1w.sv
// tb_sram_nr1w: scoreboard bench driving one OUTPUT_REG=0 and one OUTPUT_REG=1 instance with identical stimulus.
// Expected reads come from a word-array model; a negedge monitor checks data, arrival cycle and hold behaviour.
module tb_sram_nr1w;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int RP = 2;
    localparam int AW = 3;

    logic           clk = 0, rst_n = 1, clear_req = 0, write_en = 0;
    logic [RP-1:0]  read_en = '0;
    logic [RP*AW-1:0] read_addr = '0;
    logic [AW-1:0]  write_addr = '0;
    logic [3:0]     write_byte_en = '0;
    logic [DW-1:0]  write_data = '0;
    logic [RP*DW-1:0] rdat [2];
    logic [RP-1:0]  rval [2];
    logic           busy [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_nr1w #(.SETS_NUM(N), .DATA_WIDTH(DW), .READ_PORTS(RP), .OUTPUT_REG(g)) u_dut (
            .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[g]),
            .read_en(read_en), .read_addr(read_addr), .read_data(rdat[g]), .read_valid(rval[g]),
            .write_en(write_en), .write_addr(write_addr), .write_byte_en(write_byte_en),
            .write_data(write_data));
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    int            nchk = 0, nfail = 0;
    exp_t          sb [4][$];
    logic [DW-1:0] last [4];
    logic [DW-1:0] mem_m [N];
    int            busy_left = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                            input logic [3:0] be);
        logic [DW-1:0] r = o;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = w[8*k +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: the model decides what each read must return and when.
    task automatic step();
        logic [AW-1:0] ra;
        logic [DW-1:0] e;
        for (int d = 0; d < 2; d++)
            check($sformatf("busy d%0d", d), DW'(busy[d]), DW'(busy_left > 0));
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int p = 0; p < RP; p++) begin
                if (read_en[p]) begin
                    ra = read_addr[p*AW +: AW];
                    e  = (write_en && write_addr == ra) ? merge(mem_m[ra], write_data, write_byte_en)
                                                         : mem_m[ra];
                    for (int d = 0; d < 2; d++)
                        sb[d*2+p].push_back('{e, cyc + 1 + d});
                end
            end
            if (write_en) mem_m[write_addr] = merge(mem_m[write_addr], write_data, write_byte_en);
            if (clear_req) begin
                busy_left = N;
                for (int a = 0; a < N; a++) mem_m[a] = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
                      input logic we, input logic [2:0] wa, input logic [3:0] be,
                      input logic [DW-1:0] wd, input logic clr);
        read_en       = re;
        read_addr     = {a1, a0};
        write_en      = we;
        write_addr    = wa;
        write_byte_en = be;
        write_data    = wd;
        clear_req     = clr;
        step();
    endtask

    task automatic rnd(input int clr_odds);
        op(2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
           $urandom, ($urandom_range(clr_odds - 1) == 0));
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst busy d%0d", d), DW'(busy[d]), DW'(1));
            check($sformatf("rst valid d%0d", d), DW'(rval[d]), '0);
            for (int p = 0; p < RP; p++)
                check($sformatf("rst data d%0d p%0d", d, p), rdat[d][p*DW +: DW], '0);
        end
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            last[i] = '0;
        end
        @(posedge clk);
        #1;
        rst_n     = 1;
        busy_left = N;
        for (int a = 0; a < N; a++) mem_m[a] = '0;
    endtask

    always @(negedge clk) begin
        exp_t          e;
        logic [DW-1:0] v;
        int            i;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < RP; p++) begin
                    i = d * 2 + p;
                    v = rdat[d][p*DW +: DW];
                    if (rval[d][p]) begin
                        if (sb[i].size() == 0) begin
                            nchk++;
                            nfail++;
                            $display("FAIL spurious valid d%0d p%0d: got data %h want no read", d, p, v);
                        end else begin
                            e = sb[i].pop_front();
                            check($sformatf("read d%0d p%0d data", d, p), v, e.d);
                            check($sformatf("read d%0d p%0d cycle", d, p), DW'(cyc), DW'(e.due));
                            last[i] = e.d;
                        end
                    end else begin
                        if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                            nchk++;
                            nfail++;
                            $display("FAIL missing valid d%0d p%0d: got none want %h at cycle %0d",
                                     d, p, sb[i][0].d, sb[i][0].due);
                            void'(sb[i].pop_front());
                        end
                        check($sformatf("hold d%0d p%0d", d, p), v, last[i]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) last[i] = '0;
        #3;
        do_reset();
        repeat (N) rnd(1000000);
        for (int a = 0; a < N; a++) op(2'b11, 3'(a), 3'(N - 1 - a), 0, 0, 0, 0, 0);
        op(2'b00, 0, 0, 1, 3, 4'hF, 32'hDEADBEEF, 0);
        op(2'b01, 3, 0, 0, 0, 0, 0, 0);
        op(2'b00, 0, 0, 1, 5, 4'hF, 32'h11223344, 0);
        op(2'b10, 0, 5, 1, 5, 4'b0101, 32'hAABBCCDD, 0);
        op(2'b11, 5, 5, 0, 0, 0, 0, 0);
        op(2'b00, 0, 0, 1, 2, 4'hF, 32'h0000000A, 0);
        op(2'b00, 0, 0, 1, 7, 4'hF, 32'h00000070, 0);
        op(2'b11, 2, 7, 0, 0, 0, 0, 0);
        op(2'b11, 2, 2, 0, 0, 0, 0, 0);
        for (int a = 0; a < N; a++) op(2'b00, 0, 0, 1, 3'(a), 4'hF, $urandom, 0);
        op(2'b11, 1, 6, 0, 0, 0, 0, 1);
        repeat (N + 1) op(2'b11, 3'($urandom), 3'($urandom), 1, 3'($urandom), 4'hF, $urandom, 1);
        for (int a = 0; a < N; a++) op(2'b11, 3'(a), 3'(a), 0, 0, 0, 0, 0);
        repeat (400) rnd(64);
        while (busy_left > 0) rnd(1000000);
        op(2'b11, 0, 1, 1, 4, 4'hF, $urandom, 1);
        repeat (4) rnd(1000000);
        do_reset();
        repeat (12) rnd(1000000);
        repeat (200) rnd(48);
        repeat (4) op(2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) check($sformatf("drain q%0d", i), DW'(sb[i].size()), '0);
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule

// File: doc/sram_nr1w.md
SRAM_NR1W -- requirements
Module: sram_nr1w

Interface
REQ-001 SHALL have parameter SETS_NUM, default 64, number of words (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-003 SHALL have parameter READ_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter OUTPUT_REG, default 0; 1 adds one output register stage to every read port.
REQ-005 SHALL derive AW = $clog2(SETS_NUM) and BW = DATA_WIDTH/8 internally; neither is overridable.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 clear_req  in  1  request to zero the whole array.
REQ-010 busy  out  1  high while the clear sweep runs.
REQ-011 read_en  in  READ_PORTS  per-port read request; bit i belongs to port i.
REQ-012 read_addr  in  READ_PORTS*AW  port i address at [i*AW +: AW].
REQ-013 read_data  out  READ_PORTS*DATA_WIDTH  port i data at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 read_valid  out  READ_PORTS  per-port qualifier for read_data.
REQ-015 write_en  in  1  write request.
REQ-016 write_addr  in  AW  write address.
REQ-017 write_byte_en  in  BW  per-byte write mask; bit k covers data bits [8k+7:8k].
REQ-018 write_data  in  DATA_WIDTH  write data.

Function
REQ-019 Write: on a clk edge with write_en=1 and state IDLE, only the bytes of word write_addr whose write_byte_en bit is 1 SHALL update; write_byte_en=0 SHALL leave the array unchanged.
REQ-020 Read latency SHALL be 1+OUTPUT_REG cycles from the edge sampling read_en[i]=1 to read_data/read_valid[i] being presented.
REQ-021 read_valid[i] SHALL be high for exactly one cycle per accepted read; read_data port i SHALL hold its last value when no new read completes.
REQ-022 Ports SHALL be fully independent; any ports may read the same or different addresses in the same cycle.
REQ-023 Read-during-write bypass: if port i reads the write_addr in the cycle of the write, it SHALL return the merged word (written bytes from write_data, other bytes from the old contents).
REQ-024 A write in a cycle after the read was sampled SHALL NOT alter that read's data, including while it sits in the OUTPUT_REG stage.
REQ-025 Clear FSM SHALL have states IDLE and CLEAR; a sweep counter (AW bits) SHALL write all-zero to word counter each CLEAR cycle.
REQ-026 IDLE -> CLEAR on clear_req=1 (counter=0); CLEAR -> IDLE after the cycle writing word SETS_NUM-1; busy=1 exactly in CLEAR, i.e. SETS_NUM cycles.
REQ-027 In CLEAR, read_en and write_en SHALL be ignored: no write, read_valid stays 0, read_data holds. Reads already in the OUTPUT_REG stage SHALL still complete.
REQ-028 clear_req during CLEAR SHALL be ignored; no restart and no extension.
REQ-029 clear_req together with write_en/read_en in IDLE: the write and reads SHALL be performed that cycle and the sweep SHALL start next cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force state CLEAR, counter 0, busy=1, read_valid=0, read_data=0, output-stage registers=0.
REQ-031 After rst_n deasserts, the automatic sweep SHALL zero the array; array storage itself has no reset.
REQ-032 Reset asserted mid-sweep SHALL restart the sweep from word 0 for a full SETS_NUM cycles.

Verification
REQ-033 SETS_NUM=8, release rst_n -> busy high 8 cycles, then reading addresses 0..7 returns 0x00000000.
REQ-034 OUTPUT_REG=0: write addr 3 = 0xDEADBEEF, byte_en 4'hF; next cycle port0 reads 3 -> 0xDEADBEEF with read_valid[0] one cycle later. Repeat with OUTPUT_REG=1 -> data arrives two cycles after the read.
REQ-035 Addr 5 holds 0x11223344; write 0xAABBCCDD with byte_en 4'b0101 while port1 reads 5 -> port1 returns 0x11BB33DD, and a later read returns 0x11BB33DD.
REQ-036 Port0 and port1 read addr 2 (0x0A) and addr 7 (0x70) in the same cycle -> both valid together, 0x0A and 0x70; repeat with both ports on addr 2 -> both return 0x0A.
REQ-037 Pulse clear_req after filling data; assert read_en and write_en during busy -> read_valid stays 0, no write lands, and all words read 0 after busy falls.
REQ-038 Assert rst_n=0 at sweep count 4 -> outputs go to reset values at once; after release busy stays high for a full 8 cycles.
